demux_1_2: RTL and testbench
============================

Name: demux_1_2

Overview:
- Registered 1-to-2 demultiplexer: routes data input `a` to one of two outputs, selected by `s`.
- The unselected output is driven to all-zeros.
- Used as a small routing leaf wherever one stream must be steered to one of two consumers.
- Per-output valid flags, plus optional per-output route counters.

Parameters:
- WIDTH, 1, data width of a, y0, y1 (must be >= 1).
- CNT_W, 16, width of the route counters (used only with the optional feature; must be >= 1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- en  input  1  route enable; when low, the cycle routes nothing.
- a  input  WIDTH  data to route.
- s  input  1  select: 0 routes to y0, 1 routes to y1.
- y0  output  WIDTH  output 0 (registered).
- y1  output  WIDTH  output 1 (registered).
- y0_vld  output  1  y0 holds a value routed in the previous cycle.
- y1_vld  output  1  y1 holds a value routed in the previous cycle.
- Interface rule: one clock (clk); reset rst_n is synchronous and active-low.

Behaviour:
- All state updates on the rising edge of clk; no combinational input-to-output paths.
- Reset (rst_n=0 at a clock edge): y0=0, y1=0, y0_vld=0, y1_vld=0. Counters also clear when present.
  - Reset takes priority over every other input.
  - Reset mid-stream discards the in-flight value.
- en=1, s=0: next cycle y0=a, y0_vld=1, y1=0, y1_vld=0.
- en=1, s=1: next cycle y1=a, y1_vld=1, y0=0, y0_vld=0.
- en=0: next cycle y0=0, y1=0, both vld=0. Outputs do not hold stale data.
- Latency: exactly 1 cycle from input sample to output. Back-to-back routing is supported every cycle with no bubbles.
- a=0 routed: the selected output is 0 but its vld=1, which distinguishes a routed zero from an idle output.
- Invariant: y0_vld and y1_vld are never both 1.
- Invariant: an output with vld=0 always reads all-zeros.
- Select switching between consecutive cycles takes effect cleanly. The previous output returns to 0 in the same cycle the new output takes the data.
- No clock-enable or gating beyond en. No internal state other than the output registers and the optional counters.

Optional Feature:
- Macro: DEMUX_1_2_CNT_EN.
- When defined, the block adds these ports:
  - cnt_clr  input  1  synchronous clear of both counters.
  - cnt0  output  CNT_W  number of routes to y0.
  - cnt1  output  CNT_W  number of routes to y1.
- Counter rules:
  - A counter increments on each clock edge where en=1 and s selects that output.
  - Counters saturate at 2^CNT_W-1 and do not wrap.
  - cnt_clr=1 zeroes both counters and has priority over a same-cycle increment.
  - rst_n=0 zeroes both counters.
  - Counter values are visible the cycle after the counted edge.
- When not defined: these ports and all counter logic are absent, and the data-path behaviour is identical.

Test Plan:
- Reset: rst_n=0 for 2 cycles with en=1, a=1, s=1 -> y0=0, y1=0, y0_vld=0, y1_vld=0 throughout. Counters read 0.
- Route to y0: en=1, a=1, s=0 -> next cycle y0=1, y0_vld=1, y1=0, y1_vld=0.
- Route to y1 then switch: en=1, a=1, s=1 -> y1=1, y0=0. Next cycle a=0, s=0 -> y0=0 with y0_vld=1, y1=0, y1_vld=0.
- Zero data on y1: en=1, a=0, s=1 -> y0=0, y1=0, y1_vld=1.
- Enable low: en=0, a=1, s=0 -> next cycle y0=0, y1=0, both vld=0. Raising en again resumes routing with 1-cycle latency.
- With DEMUX_1_2_CNT_EN, CNT_W=2:
  - 5 routes to y0 and 2 to y1 -> cnt0=3 (saturated), cnt1=2.
  - cnt_clr=1 with a simultaneous route -> both counters read 0 the next cycle.

Source files
------------

// File: rtl/demux_1_2.sv
// Registered 1-to-2 demultiplexer with per-output valid flags.
// Define DEMUX_1_2_CNT_EN to add saturating per-output route counters.
module demux_1_2 #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic             s,
`ifdef DEMUX_1_2_CNT_EN
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
`endif
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic             y0_vld,
  output logic             y1_vld
);

  logic [WIDTH-1:0] y0_q, y0_d;
  logic [WIDTH-1:0] y1_q, y1_d;
  logic             y0_vld_q, y0_vld_d;
  logic             y1_vld_q, y1_vld_d;
  logic             route0, route1;

  assign route0 = en & ~s;
  assign route1 = en & s;

  // Unselected or idle outputs are forced to zero rather than holding stale data.
  always_comb begin
    y0_d     = '0;
    y1_d     = '0;
    y0_vld_d = route0;
    y1_vld_d = route1;
    if (route0) y0_d = a;
    if (route1) y1_d = a;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y0_q     <= '0;
      y1_q     <= '0;
      y0_vld_q <= 1'b0;
      y1_vld_q <= 1'b0;
    end else begin
      y0_q     <= y0_d;
      y1_q     <= y1_d;
      y0_vld_q <= y0_vld_d;
      y1_vld_q <= y1_vld_d;
    end
  end

  assign y0     = y0_q;
  assign y1     = y1_q;
  assign y0_vld = y0_vld_q;
  assign y1_vld = y1_vld_q;

`ifdef DEMUX_1_2_CNT_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  // Clear beats a same-cycle increment; counters stick at all-ones.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (cnt_clr) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end else begin
      if (route0 && (cnt0_q != {CNT_W{1'b1}})) cnt0_d = cnt0_q + 1'b1;
      if (route1 && (cnt1_q != {CNT_W{1'b1}})) cnt1_d = cnt1_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_demux_1_2.sv
// Directed self-checking bench for demux_1_2; counter checks apply when
// DEMUX_1_2_CNT_EN is defined (counter width 2).
module tb_demux_1_2;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [WIDTH-1:0] a;
  logic             s;
  logic [WIDTH-1:0] y0, y1;
  logic             y0_vld, y1_vld;
`ifdef DEMUX_1_2_CNT_EN
  logic             cnt_clr;
  logic [CNT_W-1:0] cnt0, cnt1;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  demux_1_2 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .a      (a),
    .s      (s),
`ifdef DEMUX_1_2_CNT_EN
    .cnt_clr(cnt_clr),
    .cnt0   (cnt0),
    .cnt1   (cnt1),
`endif
    .y0     (y0),
    .y1     (y1),
    .y0_vld (y0_vld),
    .y1_vld (y1_vld)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs, take one rising edge, then sample 1 time unit later.
  task automatic step(input logic r, input logic e, input logic [WIDTH-1:0] d, input logic sel);
    rst_n = r;
    en    = e;
    a     = d;
    s     = sel;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [WIDTH-1:0] ey0, input logic ev0,
                           input logic [WIDTH-1:0] ey1, input logic ev1);
    check({tag, ".y0"}, 32'(y0), 32'(ey0));
    check({tag, ".y0_vld"}, 32'(y0_vld), 32'(ev0));
    check({tag, ".y1"}, 32'(y1), 32'(ey1));
    check({tag, ".y1_vld"}, 32'(y1_vld), 32'(ev1));
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; a = '0; s = 1'b0;
`ifdef DEMUX_1_2_CNT_EN
    cnt_clr = 1'b0;
`endif
    @(negedge clk);

    // Reset dominates an active route request.
    step(1'b0, 1'b1, 8'h01, 1'b1);
    check_out("rst1", 8'h00, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h01, 1'b1);
    check_out("rst2", 8'h00, 1'b0, 8'h00, 1'b0);
`ifdef DEMUX_1_2_CNT_EN
    check("rst.cnt0", 32'(cnt0), 32'd0);
    check("rst.cnt1", 32'(cnt1), 32'd0);
`endif

    step(1'b1, 1'b1, 8'h01, 1'b0);
    check_out("route_y0", 8'h01, 1'b1, 8'h00, 1'b0);
    step(1'b1, 1'b1, 8'h01, 1'b1);
    check_out("route_y1", 8'h00, 1'b0, 8'h01, 1'b1);
    step(1'b1, 1'b1, 8'h00, 1'b0);
    check_out("switch_zero_y0", 8'h00, 1'b1, 8'h00, 1'b0);
    step(1'b1, 1'b1, 8'h00, 1'b1);
    check_out("zero_y1", 8'h00, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 8'h01, 1'b0);
    check_out("en_low", 8'h00, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 8'hA5, 1'b1);
    check_out("resume_y1", 8'h00, 1'b0, 8'hA5, 1'b1);
    step(1'b1, 1'b1, 8'h3C, 1'b0);
    check_out("b2b_y0", 8'h3C, 1'b1, 8'h00, 1'b0);
    step(1'b1, 1'b1, 8'hC3, 1'b1);
    check_out("b2b_y1", 8'h00, 1'b0, 8'hC3, 1'b1);
    step(1'b1, 1'b1, 8'h5A, 1'b0);
    check_out("b2b_y0b", 8'h5A, 1'b1, 8'h00, 1'b0);
    // Reset mid-stream drops the value sampled on that edge.
    step(1'b0, 1'b1, 8'hFF, 1'b0);
    check_out("rst_mid", 8'h00, 1'b0, 8'h00, 1'b0);

`ifdef DEMUX_1_2_CNT_EN
    check("rst_mid.cnt0", 32'(cnt0), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 8'(i + 1), 1'b0);
      check("cnt0_ramp", 32'(cnt0), 32'((i + 1 > 3) ? 3 : i + 1));
    end
    step(1'b1, 1'b1, 8'h11, 1'b1);
    check("cnt1_first", 32'(cnt1), 32'd1);
    step(1'b1, 1'b0, 8'h22, 1'b1);
    check("cnt1_idle", 32'(cnt1), 32'd1);
    step(1'b1, 1'b1, 8'h33, 1'b1);
    check("cnt0_sat", 32'(cnt0), 32'd3);
    check("cnt1_two", 32'(cnt1), 32'd2);
    cnt_clr = 1'b1;
    step(1'b1, 1'b1, 8'h44, 1'b1);
    cnt_clr = 1'b0;
    check("clr.cnt0", 32'(cnt0), 32'd0);
    check("clr.cnt1", 32'(cnt1), 32'd0);
    check_out("clr_route", 8'h00, 1'b0, 8'h44, 1'b1);
    step(1'b1, 1'b1, 8'h55, 1'b0);
    check("post_clr.cnt0", 32'(cnt0), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
